// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int RF_REGS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5,
    RFI  = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader_wr.sv
// Registered write-port stage: an accepted byte and its address become a
// one-cycle write pulse on the following clock. Used for both the
// instruction memory port and the register-file port.
// reset is active-low and asynchronous.
module prog_loader_wr
  import prog_loader_pkg::*;
#(
  parameter int AW = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              we,
  output logic [AW-1:0]     addr,
  output logic [BYTE_W-1:0] wdata
);

  // Delay the write request by one cycle; address and data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      we <= wr_en;
      if (wr_en) begin
        addr  <= wr_addr;
        wdata <= wr_data;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length byte, N instruction bytes and an XOR
// checksum over a valid/ready stream, writes the instructions to CPU
// instruction memory from address 0 and releases cpu_reset once verified.
// reset is active-low and asynchronous.
// Optional build macro REGFILE_INIT_EN: after a good checksum, four more
// bytes are loaded into R0..R3 through the rf_* port before release.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
`ifdef REGFILE_INIT_EN
  ,
  output logic              rf_we,
  output logic [1:0]        rf_addr,
  output logic [BYTE_W-1:0] rf_wdata
`endif
);

  localparam logic [BYTE_W-1:0] DEPTH_B = BYTE_W'(DEPTH);
  localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_inc;
  logic [BYTE_W-1:0] acc;
  logic              xfer;
  logic              data_wr;

  // Streaming states accept bytes; everything else leaves the stream untouched.
  assign in_ready  = (state == LEN) || (state == DATA) || (state == CHK) || (state == RFI);
  assign xfer      = in_valid && in_ready;
  assign count_inc = count + ONE;
  assign data_wr   = xfer && (state == DATA);

  prog_loader_wr #(.AW(ADDR_W)) u_mem_wr (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (data_wr),
    .wr_addr (count[ADDR_W-1:0]),
    .wr_data (in_data),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (mem_wdata)
  );

`ifdef REGFILE_INIT_EN
  logic [1:0] rf_count;
  logic       rf_wr;

  assign rf_wr = xfer && (state == RFI);

  prog_loader_wr #(.AW(2)) u_rf_wr (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rf_wr),
    .wr_addr (rf_count),
    .wr_data (in_data),
    .we      (rf_we),
    .addr    (rf_addr),
    .wdata   (rf_wdata)
  );
`endif

  // Frame-parsing state machine with registered status and CPU reset control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len       <= '0;
      count     <= '0;
      acc       <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef REGFILE_INIT_EN
      rf_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LEN;
        end
        LEN: begin
          if (xfer) begin
            acc <= in_data;
            if ((in_data == '0) || (in_data > DEPTH_B)) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              len   <= in_data[ADDR_W:0];
              count <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            acc   <= acc ^ in_data;
            count <= count_inc;
            if (count_inc == len) state <= CHK;
          end
        end
        CHK: begin
          if (xfer) begin
            if (in_data == acc) begin
`ifdef REGFILE_INIT_EN
              rf_count  <= '0;
              state     <= RFI;
`else
              cpu_reset <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        RFI: begin
`ifdef REGFILE_INIT_EN
          if (xfer) begin
            rf_count <= rf_count + 2'd1;
            if (rf_count == 2'(RF_REGS - 1)) begin
              cpu_reset <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
`else
          state <= IDLE;
`endif
        end
        DONE, ERR: begin
          if (start) begin
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            acc       <= '0;
            cpu_reset <= 1'b1;
            state     <= LEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized images
// compared against a frame-level model of length/data/checksum rules.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       err;
`ifdef REGFILE_INIT_EN
  logic       rf_we;
  logic [1:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [9:0] rf_q[$];
`endif

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] img[$];
  logic [12:0] wr_q[$];
  bit         use_gaps = 1'b0;

  prog_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
`ifdef REGFILE_INIT_EN
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  // Capture every write pulse shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
`ifdef REGFILE_INIT_EN
    if (rf_we) rf_q.push_back({rf_addr, rf_wdata});
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte, optionally after random idle gaps, and wait for it to transfer.
  task automatic sendByte(input logic [7:0] b);
    int waitc;
    if (use_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waitc    = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("xfer_timeout", 32'(waitc < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a load of img and check results against the frame rules.
  task automatic applyStimulus(input string tag);
    int         n;
    logic [7:0] x;
    bit         good;
    wr_q.delete();
`ifdef REGFILE_INIT_EN
    rf_q.delete();
`endif
    pulseStart();
    checkOutput({tag, "_ready_len"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_err_clear"}, 32'(err), 32'd0);
    checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
    checkOutput({tag, "_cpurst_held"}, 32'(cpu_reset), 32'd1);
    n = int'(img[0]);
    if (n == 0 || n > 32) begin
      sendByte(img[0]);
      @(negedge clk);
      checkOutput({tag, "_badlen_writes"}, 32'(wr_q.size()), 32'd0);
      checkOutput({tag, "_badlen_err"}, 32'(err), 32'd1);
      checkOutput({tag, "_badlen_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_badlen_cpurst"}, 32'(cpu_reset), 32'd1);
    end else begin
      x = 8'h00;
      for (int i = 0; i <= n; i++) x ^= img[i];
      good = (img[n+1] == x);
      for (int i = 0; i <= n; i++) sendByte(img[i]);
      checkOutput({tag, "_cpurst_prechk"}, 32'(cpu_reset), 32'd1);
      sendByte(img[n+1]);
`ifdef REGFILE_INIT_EN
      if (good) begin
        sendByte(8'h0A);
        sendByte(8'h05);
        sendByte(8'h00);
        sendByte(8'h00);
        checkOutput({tag, "_rf_count"}, 32'(rf_q.size()), 32'd4);
        checkOutput({tag, "_rf0"}, 32'(rf_q.size() > 0 ? rf_q[0] : 10'h3FF), 32'({2'd0, 8'h0A}));
        checkOutput({tag, "_rf1"}, 32'(rf_q.size() > 1 ? rf_q[1] : 10'h3FF), 32'({2'd1, 8'h05}));
        checkOutput({tag, "_rf2"}, 32'(rf_q.size() > 2 ? rf_q[2] : 10'h3FF), 32'({2'd2, 8'h00}));
        checkOutput({tag, "_rf3"}, 32'(rf_q.size() > 3 ? rf_q[3] : 10'h3FF), 32'({2'd3, 8'h00}));
      end
`endif
      checkOutput({tag, "_done"}, 32'(done), 32'(good));
      checkOutput({tag, "_err"}, 32'(err), 32'(!good));
      checkOutput({tag, "_cpurst"}, 32'(cpu_reset), 32'(!good));
      checkOutput({tag, "_ready_idle"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_nwrites"}, 32'(wr_q.size()), 32'(n));
      for (int i = 0; i < n; i++)
        checkOutput({tag, "_write"}, (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF,
                    32'({5'(i), img[i+1]}));
    end
  endtask

  // Build a valid image of the given length with random data and a correct checksum.
  task automatic makeImage(input int n);
    logic [7:0] x;
    img.delete();
    img.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < n; i++) begin
      img.push_back(8'($urandom));
      x ^= img[i+1];
    end
    img.push_back(x);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] good image");
    img = '{8'h03, 8'h0A, 8'h15, 8'h2C, 8'h30};
    applyStimulus("good");

    $display("[TB] bytes offered in DONE");
    wr_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    checkOutput("done_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    checkOutput("done_nowrite", 32'(wr_q.size()), 32'd0);
    checkOutput("done_hold", 32'(done), 32'd1);

    $display("[TB] bad checksum");
    img = '{8'h02, 8'h11, 8'h22, 8'h00};
    applyStimulus("badchk");

    $display("[TB] length bounds");
    img = '{8'h00};
    applyStimulus("len0");
    img = '{8'h21};
    applyStimulus("len33");
    makeImage(32);
    applyStimulus("len32");
    checkOutput("len32_last_addr", wr_q.size() == 32 ? 32'(wr_q[31][12:8]) : 32'hFFFF_FFFF, 32'd31);

    $display("[TB] random images with gaps");
    use_gaps = 1'b1;
    for (int k = 0; k < 8; k++) begin
      makeImage(int'($urandom_range(1, 32)));
      if ($urandom_range(0, 3) == 0) img[img.size()-1] ^= 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) begin
        img.delete();
        img.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
      end
      applyStimulus("rand");
    end
    use_gaps = 1'b0;

    $display("[TB] reset mid-load");
    pulseStart();
    sendByte(8'h05);
    sendByte(8'h5A);
    sendByte(8'hA5);
    reset = 1'b0;
    #1;
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    makeImage(5);
    applyStimulus("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader for the 8-bit CPU.
- Receives a framed image of length byte, N instruction bytes and checksum byte over a valid/ready interface, and writes the instructions into CPU instruction memory starting at address 0.
- Holds the CPU in reset until the image is verified, then releases it.
- Replaces file-based program preloading with an in-hardware write path into the same memory the control unit fetches from.

Parameters:
- DEPTH, 32, instruction memory depth in words; legal lengths are 1..DEPTH.
- ADDR_W, 5, memory address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin or restart a load; honoured only in IDLE, DONE and ERR.
- in_valid  input  1  a byte is offered on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both high.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  instruction word.
- cpu_reset  output  1  active-high reset to the CPU (clk/reset of the cpu top).
- done  output  1  image accepted and CPU released.
- err  output  1  framing or checksum failure.

Behaviour:
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, done 0, err 0, internal count 0, checksum accumulator 0.
- States: IDLE, LEN, DATA, CHK, DONE, ERR, plus RFI when REGFILE_INIT_EN is defined.
- in_ready is a decode of state: high in LEN, DATA, CHK and RFI; low elsewhere. Bytes offered outside those states are never consumed.
- IDLE: on start, go to LEN. cpu_reset stays 1.
- LEN: on transfer, latch N = in_data and set acc = in_data.
  - N = 0 or N > DEPTH goes to ERR.
  - Otherwise clear the count and go to DATA.
- DATA: on each transfer:
  - one cycle later, mem_we = 1, mem_addr = count, mem_wdata = byte (registered, latency 1);
  - acc ^= byte and count++;
  - on the Nth byte, go to CHK.
  - Back-to-back transfers must produce back-to-back writes. in_valid gaps stall without side effects.
- CHK: on transfer, compare the byte with acc.
  - Equal: go to DONE (or RFI when the feature is enabled).
  - Unequal: go to ERR. Memory contents already written are left as-is.
- DONE: cpu_reset = 0 and done = 1, registered on the DONE-entry edge.
- ERR: err = 1 and cpu_reset = 1.
- start in DONE or ERR:
  - clear done, err, count and acc;
  - reassert cpu_reset in the same edge;
  - go to LEN.
- start in LEN, DATA, CHK or RFI is ignored.
- Async reset mid-load: everything returns to its reset values immediately, including mem_we = 0. A partially written image is not erased.
- The count never wraps. At N = DEPTH the final write is to DEPTH-1.
- cpu_reset never deasserts except on entry to DONE.

Optional Feature:
- Macro: REGFILE_INIT_EN.
- When defined:
  - add outputs rf_we (1 bit), rf_addr (2 bits) and rf_wdata (8 bits), all reset to 0;
  - after a good checksum, enter RFI and accept exactly 4 more bytes;
  - write them to R0..R3 in order, with latency 1, the same timing as mem writes;
  - go to DONE after R3.
  - RFI bytes are not checksummed.
- When undefined: the rf_* ports do not exist, and CHK goes directly to DONE.

Decomposition:
- Package prog_loader_pkg holds:
  - state encoding typedef, 3 bits: IDLE=0, LEN=1, DATA=2, CHK=3, DONE=4, ERR=5, RFI=6;
  - BYTE_W = 8 and RF_REGS = 4 constants.
- One natural sub-module: prog_loader_wr, the registered write-port stage. It turns an accepted byte plus address into a one-cycle mem_we/mem_addr/mem_wdata pulse and is reused for the rf_* port.

Test Plan:
- Good image: bytes 03, 0A, 15, 2C, checksum 03^0A^15^2C=30 -> three writes at addr 0, 1, 2 with data 0A, 15, 2C; done=1; cpu_reset falls the cycle after the checksum transfer; err=0.
- Bad checksum: 02, 11, 22, then 00 (expected 31) -> two writes, then err=1, cpu_reset held 1; a following start returns to LEN with err=0.
- Length bounds: length 00 -> ERR with no writes. Length 21 (33) at DEPTH=32 -> ERR. Length 20 (32) with a valid image -> last write at addr 31, done=1.
- Backpressure and gaps: in_valid toggled randomly during DATA -> writes equal the transferred bytes only, in order, with no duplicates; in_ready is low in DONE, so extra bytes are not consumed.
- Reset mid-load: reset low after the 2nd data byte of a 5-byte image -> all outputs at reset values in the same cycle; a subsequent full load succeeds.
- REGFILE_INIT_EN: good 1-word image followed by bytes 0A, 05, 00, 00 -> rf writes R0=0A, R1=05, R2=00, R3=00, then done=1.
